// File: rtl/alu_mc_pkg.sv
// Shared types and the single-cycle ULA datapath for alu_mc.
// The combinational function works on MAX_W-bit values masked down to the active width.
package alu_pkg;

   localparam int MAX_W = 32;

   typedef enum logic [3:0] {
      ADIC = 4'b0001,
      SUB  = 4'b0010,
      OU   = 4'b0011,
      E    = 4'b0100,
      NAO  = 4'b0101,
      XOU  = 4'b0110,
      DLE  = 4'b0111,
      DLD  = 4'b1000,
      DAE  = 4'b1001,
      DAD  = 4'b1010,
      MUL  = 4'b1011,
      DIV  = 4'b1100
   } op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic b;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef struct packed {
      logic [MAX_W-1:0] res;
      flags_t           f;
      logic             err;
   } sc_res_t;

   // Operands arrive zero-extended; w is the active width (4..32).
   // MUL/DIV land in the default branch; the caller never uses that result.
   function automatic sc_res_t alu_single(input logic [3:0]       op,
                                          input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input logic             cin,
                                          input int unsigned      w);
      sc_res_t          r;
      logic [MAX_W:0]   ext;
      logic [MAX_W-1:0] mask;
      logic [4:0]       m;
      logic [5:0]       cw;
      m    = 5'(w - 1);
      cw   = 6'(w);
      mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      r    = '0;
      ext  = '0;
      case (op)
         ADIC: begin
            ext     = {1'b0, a} + {1'b0, b};
            r.res   = ext[MAX_W-1:0] & mask;
            r.f.c   = ext[cw];
            r.f.v   = (a[m] == b[m]) && (r.res[m] != a[m]);
         end
         SUB: begin
            r.res   = (a - b) & mask;
            r.f.b   = (a < b);
            r.f.v   = (a[m] != b[m]) && (r.res[m] != a[m]);
         end
         OU:  r.res = a | b;
         E:   r.res = a & b;
         XOU: r.res = a ^ b;
         NAO: r.res = ~a & mask;
         DLE: begin
            r.res   = ((a << 1) | MAX_W'(cin)) & mask;
            r.f.c   = a[m];
         end
         DLD: begin
            r.res   = (a >> 1) | (MAX_W'(cin) << m);
            r.f.c   = a[0];
         end
         DAE: begin
            r.res   = (a << 1) & mask;
            r.f.c   = a[m];
         end
         DAD: begin
            r.res   = a >> 1;
            r.f.c   = a[0];
         end
         default: r.err = 1'b1;
      endcase
      if (!r.err) begin
         r.f.n = r.res[m];
         r.f.z = (r.res == '0);
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the control unit and alu_mc.
interface alu_mc_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       operacao;
   logic [WIDTH-1:0] operA;
   logic [WIDTH-1:0] operB;
   logic             Cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             N;
   logic             Z;
   logic             C;
   logic             B;
   logic             V;
   logic             err;

   modport master (
      output in_valid, operacao, operA, operB, Cin, out_ready,
      input  in_ready, out_valid, result, result_hi, N, Z, C, B, V, err
   );

   modport slave (
      input  in_valid, operacao, operA, operB, Cin, out_ready,
      output in_ready, out_valid, result, result_hi, N, Z, C, B, V, err
   );
endinterface

// File: rtl/alu_mc_iter_md.sv
// Shared iterative engine for unsigned MUL (shift-add) and DIV (restoring).
// One iteration per clock; done pulses for one cycle after the last iteration.
module alu_iter_md #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             div_mode_i,
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] opb_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q, div_q;
   logic [WIDTH:0]   sum, rem;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // MUL: {acc,sr} shifts right with the partial sum; DIV: {acc,sr} shifts left
   // and sr collects quotient bits while acc holds the partial remainder.
   always_comb begin
      sum  = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opb_q} : '0);
      rem  = {acc_q, sr_q[WIDTH-1]};
      ge   = (rem >= {1'b0, opb_q});
      diff = rem[WIDTH-1:0] - opb_q;
      if (div_q) begin
         acc_d = ge ? diff : rem[WIDTH-1:0];
         sr_d  = {sr_q[WIDTH-2:0], ge};
      end else begin
         acc_d = sum[WIDTH:1];
         sr_d  = {sum[0], sr_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         sr_q   <= '0;
         opb_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         div_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            acc_q  <= '0;
            sr_q   <= opa_i;
            opb_q  <= opb_i;
            div_q  <= div_mode_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            acc_q <= acc_d;
            sr_q  <= sr_d;
            if (cnt_q == LAST) begin
               cnt_q  <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign lo   = sr_q;
   assign hi   = acc_q;
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle Ahmes ULA: single-cycle ops plus iterative MUL/DIV behind a
// valid/ready request port and a registered valid/ready result stage.
//
//   state | meaning
//   IDLE  | no result held, ready for a request
//   CALC  | MUL/DIV iterating, inputs ignored
//   HOLD  | result presented, waiting for out_ready
module alu_mc #(
   parameter int WIDTH = 8
) (
   input logic     clk,
   input logic     rst_n,
   alu_mc_if.slave bus
);
   import alu_pkg::*;

   state_t           state_q;
   logic [WIDTH-1:0] result_q, result_hi_q;
   flags_t           flags_q;
   logic             err_q, out_valid_q, div_q;

   logic             in_ready, accept, op_mul, op_div, b_zero, go_iter;
   logic             it_busy, it_done;
   logic [WIDTH-1:0] it_lo, it_hi;
   sc_res_t          sc;
   logic [WIDTH-1:0] imm_res, imm_hi;
   flags_t           imm_flags;
   logic             imm_err;
   logic             unused_sc;

   assign in_ready = rst_n && !it_busy &&
                     ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
   assign accept   = bus.in_valid && in_ready;
   assign op_mul   = (bus.operacao == MUL);
   assign op_div   = (bus.operacao == DIV);
   assign b_zero   = (bus.operB == '0);
   assign go_iter  = accept && (op_mul || (op_div && !b_zero));

   // Divide by zero skips the engine and answers in one cycle.
   always_comb begin
      sc        = alu_single(bus.operacao, MAX_W'(bus.operA), MAX_W'(bus.operB),
                             bus.Cin, WIDTH);
      imm_res   = sc.res[WIDTH-1:0];
      imm_hi    = '0;
      imm_flags = sc.f;
      imm_err   = sc.err;
      if (op_div && b_zero) begin
         imm_res   = '1;
         imm_hi    = bus.operA;
         imm_flags = '{n: 1'b1, z: 1'b0, c: 1'b0, b: 1'b0, v: 1'b1};
         imm_err   = 1'b1;
      end
   end
   assign unused_sc = ^sc.res;

   alu_iter_md #(.WIDTH(WIDTH)) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (go_iter),
      .div_mode_i(op_div),
      .opa_i     (bus.operA),
      .opb_i     (bus.operB),
      .busy      (it_busy),
      .done      (it_done),
      .lo        (it_lo),
      .hi        (it_hi)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         div_q       <= 1'b0;
      end else if (accept) begin
         div_q <= op_div;
         if (go_iter) begin
            state_q     <= CALC;
            out_valid_q <= 1'b0;
         end else begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= imm_res;
            result_hi_q <= imm_hi;
            flags_q     <= imm_flags;
            err_q       <= imm_err;
         end
      end else begin
         case (state_q)
            CALC: if (it_done) begin
               state_q     <= HOLD;
               out_valid_q <= 1'b1;
               result_q    <= it_lo;
               result_hi_q <= it_hi;
               err_q       <= 1'b0;
               flags_q     <= '{n: it_lo[WIDTH-1],
                                z: div_q ? (it_lo == '0) : ({it_hi, it_lo} == '0),
                                c: !div_q && (it_hi != '0),
                                b: 1'b0,
                                v: 1'b0};
            end
            HOLD: if (bus.out_ready) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.N         = flags_q.n;
   assign bus.Z         = flags_q.z;
   assign bus.C         = flags_q.c;
   assign bus.B         = flags_q.b;
   assign bus.V         = flags_q.v;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_alu_mc;
   import alu_pkg::*;

   logic clk;
   logic rst8_n, rst16_n;
   int   passes = 0;
   int   total  = 0;
   logic seen;

   alu_mc_if #(.WIDTH(8))  b8 ();
   alu_mc_if #(.WIDTH(16)) b16 ();

   alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst8_n),  .bus(b8.slave));
   alu_mc #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst16_n), .bus(b16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [31:0] fl8();
      return 32'({b8.N, b8.Z, b8.C, b8.B, b8.V});
   endfunction

   function automatic logic [31:0] fl16();
      return 32'({b16.N, b16.Z, b16.C, b16.B, b16.V});
   endfunction

   task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
      b8.in_valid = 1'b1;
      b8.operacao = op;
      b8.operA    = a;
      b8.operB    = b;
      b8.Cin      = cin;
      tick();
      b8.in_valid = 1'b0;
   endtask

   task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      b16.in_valid = 1'b1;
      b16.operacao = op;
      b16.operA    = a;
      b16.operB    = b;
      b16.Cin      = 1'b0;
      tick();
      b16.in_valid = 1'b0;
   endtask

   initial begin
      rst8_n = 1'b0;  rst16_n = 1'b0;
      b8.in_valid  = 1'b0; b8.operacao  = 4'd0; b8.operA  = 8'd0;  b8.operB  = 8'd0;
      b8.Cin  = 1'b0; b8.out_ready  = 1'b1;
      b16.in_valid = 1'b0; b16.operacao = 4'd0; b16.operA = 16'd0; b16.operB = 16'd0;
      b16.Cin = 1'b0; b16.out_ready = 1'b1;
      tick();
      tick();

      // reset state
      chk("rst_valid",  32'(b8.out_valid), 32'd0);
      chk("rst_result", 32'({b8.result, b8.result_hi}), 32'd0);
      chk("rst_flags",  fl8(), 32'd0);
      chk("rst_err",    32'(b8.err), 32'd0);
      chk("rst_ready",  32'(b8.in_ready), 32'd0);
      rst8_n = 1'b1; rst16_n = 1'b1;
      #1;
      chk("idle_ready", 32'(b8.in_ready), 32'd1);

      // single-cycle ops, back to back with out_ready=1
      issue8(ADIC, 8'd127, 8'd1, 1'b0);
      chk("add1_valid", 32'(b8.out_valid), 32'd1);
      chk("add1_res",   32'(b8.result), 32'd128);
      chk("add1_flags", fl8(), 32'b10001);
      issue8(ADIC, 8'd255, 8'd1, 1'b0);
      chk("add2_res",   32'(b8.result), 32'd0);
      chk("add2_flags", fl8(), 32'b01100);
      issue8(SUB, 8'd0, 8'd1, 1'b0);
      chk("sub_res",    32'(b8.result), 32'd255);
      chk("sub_flags",  fl8(), 32'b10010);
      issue8(DLE, 8'd129, 8'd0, 1'b1);
      chk("dle_res",    32'(b8.result), 32'd3);
      chk("dle_flags",  fl8(), 32'b00100);
      issue8(DLD, 8'd129, 8'd0, 1'b1);
      chk("dld_res",    32'(b8.result), 32'd192);
      chk("dld_flags",  fl8(), 32'b10100);
      issue8(DAE, 8'h81, 8'd0, 1'b1);
      chk("dae_res",    32'(b8.result), 32'h02);
      chk("dae_flags",  fl8(), 32'b00100);
      issue8(DAD, 8'h81, 8'd0, 1'b1);
      chk("dad_res",    32'(b8.result), 32'h40);
      issue8(XOU, 8'hF0, 8'hFF, 1'b0);
      chk("xou_res",    32'(b8.result), 32'h0F);
      issue8(E, 8'hF0, 8'h0F, 1'b0);
      chk("e_flags",    fl8(), 32'b01000);
      issue8(NAO, 8'h5A, 8'h00, 1'b0);
      chk("nao_res",    32'({b8.result_hi, b8.result}), 32'h00A5);
      issue8(4'b0000, 8'd9, 8'd9, 1'b0);
      chk("ill8_err",   32'(b8.err), 32'd1);
      chk("ill8_out",   32'({b8.result, b8.result_hi}), 32'd0);
      chk("ill8_flags", fl8(), 32'd0);

      // MUL 200*3: nine edges, in_ready low until the result appears
      issue8(MUL, 8'd200, 8'd3, 1'b0);
      for (int k = 0; k < 9; k++) begin
         chk("mul8_busy", 32'({b8.out_valid, b8.in_ready}), 32'd0);
         tick();
      end
      chk("mul8_valid", 32'(b8.out_valid), 32'd1);
      chk("mul8_res",   32'({b8.result_hi, b8.result}), 32'h0258);
      chk("mul8_flags", fl8(), 32'b00100);
      chk("mul8_err",   32'(b8.err), 32'd0);

      // DIV 200/7
      issue8(DIV, 8'd200, 8'd7, 1'b0);
      for (int k = 0; k < 9; k++) begin
         chk("div8_busy", 32'(b8.out_valid), 32'd0);
         tick();
      end
      chk("div8_valid", 32'(b8.out_valid), 32'd1);
      chk("div8_res",   32'({b8.result_hi, b8.result}), 32'h041C);
      chk("div8_flags", fl8(), 32'b00000);

      // DIV by zero, latency 1
      issue8(DIV, 8'd5, 8'd0, 1'b0);
      chk("div0_valid", 32'(b8.out_valid), 32'd1);
      chk("div0_res",   32'({b8.result_hi, b8.result}), 32'h05FF);
      chk("div0_err",   32'(b8.err), 32'd1);
      chk("div0_v",     32'(b8.V), 32'd1);

      // backpressure: result held while a new request waits
      issue8(OU, 8'h0F, 8'h30, 1'b0);
      b8.out_ready = 1'b0;
      b8.in_valid  = 1'b1;
      b8.operacao  = ADIC;
      b8.operA     = 8'd1;
      b8.operB     = 8'd2;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold", 32'({b8.out_valid, b8.in_ready, b8.result}), 32'h23F);
      end
      b8.out_ready = 1'b1;
      #1;
      chk("bp_ready", 32'(b8.in_ready), 32'd1);
      tick();
      b8.in_valid = 1'b0;
      chk("bp_next",  32'({b8.out_valid, b8.result}), 32'h103);

      // reset in the middle of a MUL
      issue8(MUL, 8'd200, 8'd3, 1'b0);
      tick();
      tick();
      tick();
      rst8_n = 1'b0;
      tick();
      chk("mrst_out",   32'({b8.out_valid, b8.err, b8.result, b8.result_hi}), 32'd0);
      chk("mrst_flags", fl8(), 32'd0);
      chk("mrst_ready", 32'(b8.in_ready), 32'd0);
      rst8_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 14; k++) begin
         tick();
         seen = seen | b8.out_valid;
      end
      chk("mrst_novalid", 32'(seen), 32'd0);

      // WIDTH=16: MUL 0xFFFF*0xFFFF, seventeen edges
      issue16(MUL, 16'hFFFF, 16'hFFFF);
      for (int k = 0; k < 17; k++) begin
         chk("mul16_busy", 32'({b16.out_valid, b16.in_ready}), 32'd0);
         tick();
      end
      chk("mul16_valid", 32'(b16.out_valid), 32'd1);
      chk("mul16_res",   32'({b16.result_hi, b16.result}), 32'hFFFE0001);
      chk("mul16_flags", fl16(), 32'b00100);

      issue16(4'b1111, 16'h1234, 16'h5678);
      chk("ill16_err",   32'({b16.out_valid, b16.err}), 32'd3);
      chk("ill16_out",   32'({b16.result_hi, b16.result}), 32'd0);
      chk("ill16_flags", fl16(), 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
